// File: rtl/sd_pkg.sv
// Shared definitions for the SD card SPI-mode initialisation controller.
// Holds the controller state enum, the command phase enum, SD command index,
// argument and CRC constants, R1 response bit positions, and a helper that
// builds the fixed command word for each initialisation state.
package sd_pkg;

    typedef enum logic [2:0] {
        StDummy,
        StCmd0,
        StCmd8,
        StCmd55,
        StAcmd41,
        StReady,
        StHost,
        StError
    } sd_state_e;

    // Every command state first offers the command, then waits for its R1.
    typedef enum logic {
        PhIssue,
        PhWait
    } sd_phase_e;

    localparam logic [5:0] CmdIdx0  = 6'd0;
    localparam logic [5:0] CmdIdx8  = 6'd8;
    localparam logic [5:0] CmdIdx41 = 6'd41;
    localparam logic [5:0] CmdIdx55 = 6'd55;

    localparam logic [6:0] Crc0    = 7'h4A;
    localparam logic [6:0] Crc8    = 7'h43;
    // SPI mode ignores the CRC after CMD8, so all-ones is sent.
    localparam logic [6:0] CrcNone = 7'h7F;

    localparam logic [31:0] Cmd8Arg      = 32'h0000_01AA;
    localparam logic [31:0] Acmd41HcsArg = 32'h4000_0000;

    localparam int unsigned R1IdleBit    = 0;
    localparam int unsigned R1IllegalBit = 2;

    localparam logic [7:0] R1Idle   = 8'(1 << R1IdleBit);
    localparam logic [7:0] R1Ok     = 8'h00;
    localparam logic [7:0] R1V1Card = 8'(R1Idle | 8'(1 << R1IllegalBit));
    localparam logic [7:0] R1Reset  = 8'hFF;

    typedef struct packed {
        logic [5:0]  index;
        logic [31:0] arg;
        logic [6:0]  crc;
    } sd_cmd_t;

    // Command word issued on entry to an initialisation state.
    function automatic sd_cmd_t init_cmd(sd_state_e st, logic card_v2);
        sd_cmd_t c;
        c.index = CmdIdx0;
        c.arg   = '0;
        c.crc   = CrcNone;
        case (st)
            StCmd0: begin
                c.crc = Crc0;
            end
            StCmd8: begin
                c.index = CmdIdx8;
                c.arg   = Cmd8Arg;
                c.crc   = Crc8;
            end
            StCmd55: begin
                c.index = CmdIdx55;
            end
            StAcmd41: begin
                c.index = CmdIdx41;
                c.arg   = card_v2 ? Acmd41HcsArg : '0;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sd_rsp_timer.sv
// Response timeout counter for the SD initialisation controller.
// load_i arms the counter with Timeout, clear_i stops it, otherwise it counts
// down to zero. expired_o is high in the last cycle of the window so the
// owner leaves its wait state exactly Timeout cycles after load_i.
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   load_i     start a new timeout window (handshake cycle)
//   clear_i    stop the counter (response seen or window abandoned)
//   expired_o  window ends on this clock edge
module sd_rsp_timer #(
    parameter int unsigned Timeout = 65535
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic clear_i,
    output logic expired_o
);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = 32'(Timeout);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == 32'd1);

endmodule

// File: rtl/sd_init_ctrl.sv
// SD card SPI-mode initialisation controller.
// Sequences dummy clocks, CMD0, optional CMD8, CMD55/ACMD41 retries, then
// drops to the fast clock and forwards single host commands to the SPI
// command engine. Any bad R1 or response timeout parks it in a sticky error
// state until reset.
// Build option: define SD_CMD8_EN to issue CMD8 and detect v2 cards;
// without it CMD0 is followed directly by CMD55 and card_v2 stays 0.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   chip_select, write,          host write port: [5:0] index, [31:8] arg
//   writedata
//   readdata                     status: [7:0] last R1, [8] busy, [9] ready,
//                                [10] error, [11] card_v2
//   cmd_valid/cmd_ready,         command handshake and fields to the engine
//   cmd_index/cmd_arg/cmd_crc
//   rsp_valid/rsp_byte           one-cycle R1 pulse from the engine
//   slow_clk_sel                 1 selects the <400 kHz SD clock
//   dummy_req/dummy_done         80 dummy clocks request and completion
module sd_init_ctrl #(
    parameter int unsigned ACMD41_RETRIES = 255,
    parameter int unsigned RSP_TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chip_select,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic [6:0]  cmd_crc,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_byte,
    output logic        slow_clk_sel,
    output logic        dummy_req,
    input  logic        dummy_done
);

    import sd_pkg::*;

`ifdef SD_CMD8_EN
    localparam sd_state_e AfterCmd0 = StCmd8;
`else
    localparam sd_state_e AfterCmd0 = StCmd55;
`endif

    sd_state_e   state_q, state_d;
    sd_phase_e   phase_q, phase_d;
    sd_cmd_t     cmd_q, cmd_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        dummy_req_q, dummy_req_d;
    logic        slow_clk_q, slow_clk_d;
    logic [7:0]  last_r1_q, last_r1_d;
    logic        card_v2_q, card_v2_d;
    logic [31:0] retry_q, retry_d;

    logic tmr_load, tmr_clear, tmr_expired;
    logic in_cmd, hs, rsp_take, timeout, launch;
    logic busy, ready, error;

    logic unused_wd;
    assign unused_wd = ^writedata[7:6];

    assign in_cmd   = state_q inside {StCmd0, StCmd8, StCmd55, StAcmd41, StHost};
    assign hs       = in_cmd && (phase_q == PhIssue) && cmd_valid_q && cmd_ready;
    assign rsp_take = in_cmd && (phase_q == PhWait) && rsp_valid;
    // A response arriving on the last cycle of the window still counts.
    assign timeout  = in_cmd && (phase_q == PhWait) && !rsp_valid && tmr_expired;

    sd_rsp_timer #(
        .Timeout(RSP_TIMEOUT)
    ) u_rsp_timer (
        .clk_i    (clk),
        .rst_ni   (reset_n),
        .load_i   (tmr_load),
        .clear_i  (tmr_clear),
        .expired_o(tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        dummy_req_d = 1'b0;
        slow_clk_d  = slow_clk_q;
        last_r1_d   = last_r1_q;
        card_v2_d   = card_v2_q;
        retry_d     = retry_q;
        tmr_load    = 1'b0;
        tmr_clear   = 1'b0;
        launch      = 1'b0;

        case (state_q)
            StDummy: begin
                if (dummy_req_q && dummy_done) begin
                    state_d = StCmd0;
                    launch  = 1'b1;
                end else begin
                    dummy_req_d = 1'b1;
                end
            end
            StReady: begin
                if (chip_select && write) begin
                    state_d     = StHost;
                    phase_d     = PhIssue;
                    cmd_valid_d = 1'b1;
                    cmd_d.index = writedata[5:0];
                    cmd_d.arg   = {8'h00, writedata[31:8]};
                    cmd_d.crc   = CrcNone;
                end
            end
            StError: ;
            default: begin
                if (hs) begin
                    cmd_valid_d = 1'b0;
                    phase_d     = PhWait;
                    tmr_load    = 1'b1;
                end else if (rsp_take) begin
                    tmr_clear = 1'b1;
                    last_r1_d = rsp_byte;
                    case (state_q)
                        StCmd0: begin
                            state_d = (rsp_byte == R1Idle) ? AfterCmd0 : StError;
                        end
                        StCmd8: begin
`ifdef SD_CMD8_EN
                            if (rsp_byte == R1Idle) begin
                                card_v2_d = 1'b1;
                                state_d   = StCmd55;
                            end else if (rsp_byte == R1V1Card) begin
                                state_d = StCmd55;
                            end else begin
                                state_d = StError;
                            end
`else
                            state_d = StError;
`endif
                        end
                        StCmd55: begin
                            state_d = rsp_byte[R1IllegalBit] ? StError : StAcmd41;
                        end
                        StAcmd41: begin
                            if (rsp_byte == R1Ok) begin
                                state_d = StReady;
                            end else if (rsp_byte == R1Idle) begin
                                retry_d = retry_q + 32'd1;
                                state_d = (retry_d >= ACMD41_RETRIES) ? StError : StCmd55;
                            end else begin
                                state_d = StError;
                            end
                        end
                        StHost: begin
                            state_d = StReady;
                        end
                        default: begin
                            state_d = StError;
                        end
                    endcase
                    launch = state_d inside {StCmd8, StCmd55, StAcmd41};
                end else if (timeout) begin
                    tmr_clear = 1'b1;
                    state_d   = StError;
                end
            end
        endcase

        if (launch) begin
            cmd_valid_d = 1'b1;
            phase_d     = PhIssue;
            cmd_d       = init_cmd(state_d, card_v2_d);
        end
        if (state_d == StReady) begin
            slow_clk_d = 1'b0;
        end
        if (state_d == StError) begin
            cmd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StDummy;
            phase_q     <= PhIssue;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            dummy_req_q <= 1'b0;
            slow_clk_q  <= 1'b1;
            last_r1_q   <= R1Reset;
            card_v2_q   <= 1'b0;
            retry_q     <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            dummy_req_q <= dummy_req_d;
            slow_clk_q  <= slow_clk_d;
            last_r1_q   <= last_r1_d;
            card_v2_q   <= card_v2_d;
            retry_q     <= retry_d;
        end
    end

    assign busy  = !(state_q inside {StReady, StError});
    assign ready = state_q inside {StReady, StHost};
    assign error = (state_q == StError);

    assign readdata     = {20'h0_0000, card_v2_q, error, ready, busy, last_r1_q};
    assign cmd_valid    = cmd_valid_q;
    assign cmd_index    = cmd_q.index;
    assign cmd_arg      = cmd_q.arg;
    assign cmd_crc      = cmd_q.crc;
    assign slow_clk_sel = slow_clk_q;
    assign dummy_req    = dummy_req_q;

endmodule

// File: tb/tb_sd_init_ctrl.sv
// Bench for sd_init_ctrl: plays the SPI engine and card with randomised
// handshake/response delays and R1 choices; the expected command stream and
// final status are derived from the card initialisation rules.
module tb_sd_init_ctrl;

    localparam int unsigned Retries = 3;
    localparam int unsigned Timeout = 16;
`ifdef SD_CMD8_EN
    localparam bit Cmd8En = 1'b1;
`else
    localparam bit Cmd8En = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        chip_select = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [6:0]  cmd_crc;
    logic        rsp_valid = 1'b0;
    logic [7:0]  rsp_byte = '0;
    logic        slow_clk_sel;
    logic        dummy_req;
    logic        dummy_done = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sd_init_ctrl #(
        .ACMD41_RETRIES(Retries),
        .RSP_TIMEOUT   (Timeout)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .chip_select (chip_select),
        .write       (write),
        .writedata   (writedata),
        .readdata    (readdata),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .cmd_crc     (cmd_crc),
        .rsp_valid   (rsp_valid),
        .rsp_byte    (rsp_byte),
        .slow_clk_sel(slow_clk_sel),
        .dummy_req   (dummy_req),
        .dummy_done  (dummy_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        chip_select = 1'b0; write = 1'b0; writedata = '0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_byte = '0; dummy_done = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic serve_dummy();
        int n = 0;
        while (!dummy_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("dummy_req", 32'(dummy_req), 32'd1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        dummy_done = 1'b1;
        @(negedge clk);
        dummy_done = 1'b0;
    endtask

    task automatic expect_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                              input logic [6:0] crc);
        int n = 0;
        while (!cmd_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_valid"}, 32'(cmd_valid), 32'd1);
        check_eq({tag, "_index"}, 32'(cmd_index), 32'(idx));
        check_eq({tag, "_arg"}, cmd_arg, arg);
        check_eq({tag, "_crc"}, 32'(cmd_crc), 32'(crc));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check_eq({tag, "_hold"}, cmd_arg, arg);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check_eq({tag, "_drop"}, 32'(cmd_valid), 32'd0);
    endtask

    // R1 lands 1..Timeout-4 cycles after the handshake, inside the window.
    task automatic respond(input logic [7:0] r1);
        repeat ($urandom_range(0, Timeout - 5)) @(negedge clk);
        rsp_valid = 1'b1;
        rsp_byte  = r1;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_byte  = 8'($urandom);
    endtask

    // ones: ACMD41 R1=01 answers before the 00; ones >= Retries exhausts.
    task automatic run_init(input bit v2, input int ones, input string tag);
        bit v2_exp;
        v2_exp = v2 & Cmd8En;
        serve_dummy();
        expect_cmd("cmd0", 6'd0, 32'h0, 7'h4A);
        respond(8'h01);
`ifdef SD_CMD8_EN
        expect_cmd("cmd8", 6'd8, 32'h0000_01AA, 7'h43);
        respond(v2 ? 8'h01 : 8'h05);
`endif
        for (int i = 0; i <= ones && i < int'(Retries); i++) begin
            expect_cmd("cmd55", 6'd55, 32'h0, 7'h7F);
            respond(8'($urandom) & 8'hFB);
            expect_cmd("acmd41", 6'd41, v2_exp ? 32'h4000_0000 : 32'h0, 7'h7F);
            respond(i < ones ? 8'h01 : 8'h00);
        end
        if (ones >= int'(Retries)) begin
            check_eq({tag, "_status"}, 32'(readdata[11:8]), 32'({v2_exp, 3'b100}));
            check_eq({tag, "_r1"}, 32'(readdata[7:0]), 32'h01);
            check_eq({tag, "_slow"}, 32'(slow_clk_sel), 32'd1);
            check_eq({tag, "_valid"}, 32'(cmd_valid), 32'd0);
        end else begin
            check_eq({tag, "_status"}, 32'(readdata[11:8]), 32'({v2_exp, 3'b010}));
            check_eq({tag, "_r1"}, 32'(readdata[7:0]), 32'h00);
            check_eq({tag, "_slow"}, 32'(slow_clk_sel), 32'd0);
        end
    endtask

    task automatic host_cmd(input logic [31:0] wd, input logic [7:0] r1);
        chip_select = 1'b0; write = 1'b1; writedata = ~wd;
        @(negedge clk);
        write = 1'b0;
        check_eq("host_nocs", 32'(cmd_valid), 32'd0);
        chip_select = 1'b1; write = 1'b1; writedata = wd;
        @(negedge clk);
        chip_select = 1'b0; write = 1'b0;
        expect_cmd("host", wd[5:0], {8'h00, wd[31:8]}, 7'h7F);
        check_eq("host_busy", 32'(readdata[8]), 32'd1);
        chip_select = 1'b1; write = 1'b1; writedata = $urandom;
        @(negedge clk);
        chip_select = 1'b0; write = 1'b0;
        respond(r1);
        check_eq("host_r1", 32'(readdata[7:0]), 32'(r1));
        check_eq("host_idle", 32'(readdata[9:8]), 32'b10);
        repeat (3) @(negedge clk);
        check_eq("host_noqueue", 32'(cmd_valid), 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] bad;

        // Reset state and the first dummy request
        repeat (2) @(negedge clk);
        check_eq("rst_readdata", readdata, 32'h0000_01FF);
        check_eq("rst_cmd", {cmd_valid, 7'h0, cmd_crc, 2'b0, cmd_index}, 32'h0);
        check_eq("rst_arg", cmd_arg, 32'h0);
        check_eq("rst_dummy", 32'(dummy_req), 32'd0);
        check_eq("rst_slow", 32'(slow_clk_sel), 32'd1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_dummy_rise", 32'(dummy_req), 32'd1);

        // Nominal card with one ACMD41 retry, then host commands
        run_init(1'b1, 1, "nominal");
        host_cmd(32'h0000_0211, 8'h00);
        check_eq("host_index17", 32'(cmd_index), 32'd17);
        for (int i = 0; i < 3; i++) host_cmd($urandom, 8'($urandom));

        // v1 card and retry exhaustion
        do_reset();
        run_init(1'b0, 0, "v1");
        do_reset();
        run_init(1'b1, int'(Retries), "exhaust");
        chip_select = 1'b1; write = 1'b1; writedata = 32'h0000_0211;
        @(negedge clk);
        chip_select = 1'b0; write = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("err_sticky", 32'(readdata[10]), 32'd1);
        check_eq("err_novalid", 32'(cmd_valid), 32'd0);

        for (int i = 0; i < 4; i++) begin
            do_reset();
            run_init(1'($urandom), int'($urandom_range(0, Retries)), "rand");
        end

        // Timeout after the CMD0 handshake
        do_reset();
        serve_dummy();
        expect_cmd("to_cmd0", 6'd0, 32'h0, 7'h4A);
        repeat (Timeout - 1) @(negedge clk);
        check_eq("to_before", 32'(readdata[10]), 32'd0);
        @(negedge clk);
        check_eq("to_error", 32'(readdata[10]), 32'd1);
        check_eq("to_novalid", 32'(cmd_valid), 32'd0);

        // Bad CMD0 response
        do_reset();
        serve_dummy();
        expect_cmd("bad_cmd0", 6'd0, 32'h0, 7'h4A);
        bad = 8'($urandom_range(2, 255));
        respond(bad);
        check_eq("bad_cmd0_err", 32'(readdata[10:8]), 32'b100);
        check_eq("bad_cmd0_r1", 32'(readdata[7:0]), 32'(bad));

        // Reset during the CMD55 wait
        do_reset();
        serve_dummy();
        expect_cmd("rc_cmd0", 6'd0, 32'h0, 7'h4A);
        respond(8'h01);
`ifdef SD_CMD8_EN
        expect_cmd("rc_cmd8", 6'd8, 32'h0000_01AA, 7'h43);
        respond(8'h01);
`endif
        expect_cmd("rc_cmd55", 6'd55, 32'h0, 7'h7F);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rc_cmd", {cmd_valid, 7'h0, cmd_crc, 2'b0, cmd_index}, 32'h0);
        check_eq("rc_arg", cmd_arg, 32'h0);
        check_eq("rc_dummy", 32'(dummy_req), 32'd0);
        check_eq("rc_slow", 32'(slow_clk_sel), 32'd1);
        check_eq("rc_readdata", readdata, 32'h0000_01FF);
        @(negedge clk);
        reset_n = 1'b1;
        check_eq("rc_dummy_low", 32'(dummy_req), 32'd0);
        @(posedge clk);
        #1;
        check_eq("rc_dummy_rise", 32'(dummy_req), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sd_init_ctrl.md
SD_INIT_CTRL -- requirements
Module: sd_init_ctrl

Interface
REQ-001 SHALL port: clk  in  1  single system clock; all logic on its rising edge.
REQ-002 SHALL port: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL port: chip_select  in  1  host access qualifier.
REQ-004 SHALL port: write  in  1  host write strobe; acts only with chip_select=1.
REQ-005 SHALL port: writedata  in  32  host command: [5:0] index, [31:8] arg[23:0].
REQ-006 SHALL port: readdata  out  32  status: [7:0] last R1, [8] busy, [9] ready, [10] error, [11] card_v2, [31:12] zero.
REQ-007 SHALL port: cmd_valid / cmd_ready  out/in  1/1  command handshake to the SPI command engine; transfer when both are 1.
REQ-008 SHALL port: cmd_index / cmd_arg / cmd_crc  out  6/32/7  command fields, held stable while cmd_valid=1.
REQ-009 SHALL port: rsp_valid / rsp_byte  in  1/8  one-cycle R1 response pulse from the engine.
REQ-010 SHALL port: slow_clk_sel  out  1  1 selects the <400 kHz SD clock; 0 selects the fast clock.
REQ-011 SHALL port: dummy_req / dummy_done  out/in  1/1  request for 80 clocks with CS high and MOSI high; done is a one-cycle pulse.
REQ-012 SHALL parameter: ACMD41_RETRIES, default 255, maximum CMD55/ACMD41 pairs.
REQ-013 SHALL parameter: RSP_TIMEOUT, default 65535, clk cycles between handshake and rsp_valid before error.

Function
REQ-014 SHALL FSM states: DUMMY, CMD0, CMD8, CMD55, ACMD41, READY, HOST, ERROR; each CMD state has ISSUE (cmd_valid=1) and WAIT (cmd_valid=0, timer running) phases.
REQ-015 SHALL DUMMY: hold dummy_req=1 until dummy_done, then go to CMD0.
REQ-016 SHALL CMD0: index 0, arg 0, crc 7'h4A; R1=8'h01 goes to CMD8 (or CMD55 without the macro); any other R1 goes to ERROR.
REQ-017 SHALL CMD55: index 55, arg 0; R1 with bit 2 (illegal) set goes to ERROR, otherwise to ACMD41.
REQ-018 SHALL ACMD41: index 41, arg 32'h4000_0000 if card_v2 else 0; R1=8'h00 goes to READY; R1=8'h01 increments the retry count and returns to CMD55; reaching ACMD41_RETRIES goes to ERROR.
REQ-019 SHALL drive cmd_crc=7'h7F for every command except CMD0 and CMD8.
REQ-020 SHALL keep slow_clk_sel=1 in all states before READY, and clear it on entry to READY.
REQ-021 SHALL, in READY, accept a host write: latch index and arg {8'h00, writedata[31:8]}, go to HOST, set busy, and return to READY on the R1 with last R1 updated.
REQ-022 SHALL ignore host writes outside READY (no state change, no queueing).
REQ-023 SHALL go to ERROR on any timeout; ERROR is sticky until reset, with cmd_valid=0 and error=1.
REQ-024 SHALL ignore rsp_valid outside a WAIT phase.
REQ-025 SHALL update readdata combinationally from registers every cycle.
REQ-026 SHALL have busy=1 in every state except READY and ERROR.

Reset
REQ-027 SHALL reset to: state DUMMY, cmd_valid=0, cmd_index=0, cmd_arg=0, cmd_crc=0, dummy_req=0, slow_clk_sel=1, last R1=8'hFF, error=0, card_v2=0, retry count 0, timer 0.
REQ-028 SHALL, on reset asserted mid-command, abandon the handshake immediately; dummy_req rises on the first clk after release.

Configuration
REQ-029 SHALL with SD_CMD8_EN defined: issue CMD8 (index 8, arg 32'h0000_01AA, crc 7'h43); R1=8'h01 sets card_v2=1; R1=8'h05 leaves card_v2=0; both then go to CMD55; any other R1 goes to ERROR.
REQ-030 SHALL without SD_CMD8_EN: omit the CMD8 state, go from CMD0 directly to CMD55, and hold card_v2=0.

Structure
REQ-031 SHALL use shared package sd_pkg for the state enum, command index constants (0, 8, 41, 55), CRC constants, and R1 bit positions.
REQ-032 SHALL instantiate sub-module sd_rsp_timer (load/clear/expire counter) for RSP_TIMEOUT.

Verification
REQ-033 SHALL test the nominal v2 card: R1 01 (CMD0), 01 (CMD8), then 01,00 on ACMD41 -> READY with card_v2=1, slow_clk_sel=0, readdata[11:8]=4'b1010.
REQ-034 SHALL test the v1 card: CMD8 R1=8'h05 -> ACMD41 arg=0, card_v2=0, reaches READY.
REQ-035 SHALL test retry exhaustion: with ACMD41_RETRIES=3, three ACMD41 R1=8'h01 -> ERROR, error=1, cmd_valid=0.
REQ-036 SHALL test timeout: with RSP_TIMEOUT=16, no rsp_valid after CMD0 handshake -> ERROR exactly 16 cycles after the handshake.
REQ-037 SHALL test a host command: in READY, write 32'h0000_0211 -> cmd_index=17, cmd_arg=32'h0000_0002, busy=1 until R1=8'h00, then readdata[7:0]=8'h00 and busy=0.
REQ-038 SHALL test reset during the CMD55 WAIT phase -> all outputs at reset values, then dummy_req=1 one clk after release.
